segvect_match: RTL and testbench

Pipelined match resolver placed directly downstream of the segment vector memory. Each lookup delivers 13 segment words (one per 8-bit key slice). This block:
- checks that all 13 words are valid and agree on a segment ID,
- ANDs their rule masks,
- priority-encodes the lowest surviving rule into a rule ID,
- keeps lookup/hit statistics.

Its output feeds the action/result stage.

---
 rtl/segvect_match.sv | 190 +++++++++++++++++++
 tb/tb_segvect_match.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/segvect_match.sv
// Match resolver behind the segment vector memory: it validates and ID-checks 13 segment words,
// ANDs their rule masks, priority-encodes the lowest surviving rule, and keeps lookup and hit counts.

module segvect_lane #(
    parameter int MASKWID = 13,
    parameter int IDWID   = 8,
    parameter int DATA    = 23
) (
    input  logic [DATA-1:0]    word,
    output logic               v,
    output logic               wc,
    output logic [IDWID-1:0]   id,
    output logic [MASKWID-1:0] emask
);
    assign v     = word[DATA-1];
    assign wc    = word[DATA-2];
    assign id    = word[MASKWID +: IDWID];
    // A wildcarded segment does not restrict the rule set.
    assign emask = wc ? '1 : word[MASKWID-1:0];
endmodule

module segvect_match #(
    parameter int KWID    = 104,
    parameter int NSEG    = KWID / 8,
    parameter int MASKWID = 13,
    parameter int SEGWID  = 10,
    parameter int IDWID   = SEGWID - 2,
    parameter int DATA    = MASKWID + SEGWID,
    parameter int VTWID   = DATA * NSEG,
    parameter int IXWID   = 4,
    parameter int CNTWID  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [VTWID-1:0]       rdi,
    input  logic                   ivld,
    input  logic                   clr,
    output logic                   ovld,
    output logic                   hit,
    output logic [IDWID+IXWID-1:0] ruleid,
    output logic                   multi,
    output logic                   err,
    output logic [CNTWID-1:0]      lkcnt,
    output logic [CNTWID-1:0]      hitcnt
);
    localparam int STAGES = 2;

    typedef struct packed {
        logic               allv;
        logic               idok;
        logic [IDWID-1:0]   refid;
        logic [MASKWID-1:0] andm;
    } s2_t;

    typedef struct packed {
        logic                   hit;
        logic                   multi;
        logic                   errev;
        logic [IDWID+IXWID-1:0] ruleid;
    } s3_t;

    logic [STAGES:0]              vld_pipe_q, vld_pipe_d;
    logic [VTWID-1:0]             rdi_q, rdi_d;
    s2_t                          s2_q, s2_d;
    s3_t                          s3_q, s3_d;
    logic                         ovld_q, ovld_d;
    logic                         hit_q, hit_d;
    logic [IDWID+IXWID-1:0]       ruleid_q, ruleid_d;
    logic                         multi_q, multi_d;
    logic                         err_q, err_d;
    logic [CNTWID-1:0]            lkcnt_q, lkcnt_d;
    logic [CNTWID-1:0]            hitcnt_q, hitcnt_d;

    logic [NSEG-1:0]              lane_v, lane_wc, id_bad;
    logic [NSEG-1:0][IDWID-1:0]   lane_id;
    logic [NSEG-1:0][MASKWID-1:0] lane_emask;
    logic [IDWID-1:0]             refid_c;
    logic [MASKWID-1:0]           andm_c;
    logic [IXWID-1:0]             idx_c;
    logic                         hit_c;

    for (genvar k = 0; k < NSEG; k++) begin : g_lane
        segvect_lane #(.MASKWID(MASKWID), .IDWID(IDWID), .DATA(DATA)) u_lane (
            .word  (rdi_q[DATA*k +: DATA]),
            .v     (lane_v[k]),
            .wc    (lane_wc[k]),
            .id    (lane_id[k]),
            .emask (lane_emask[k])
        );
        assign id_bad[k] = !lane_wc[k] && (lane_id[k] != refid_c);
    end

    // The reference ID comes from the lowest non-wildcard word; segment 0 is used if every word is wildcarded.
    always_comb begin
        refid_c = lane_id[0];
        for (int k = NSEG - 1; k >= 0; k--)
            if (!lane_wc[k]) refid_c = lane_id[k];
    end

    always_comb begin
        andm_c = '1;
        for (int k = 0; k < NSEG; k++) andm_c &= lane_emask[k];
    end

    always_comb begin
        idx_c = '0;
        for (int i = MASKWID - 1; i >= 0; i--)
            if (s2_q.andm[i]) idx_c = IXWID'(i);
    end

    assign hit_c = s2_q.allv && s2_q.idok && (s2_q.andm != '0);

    always_comb begin
        vld_pipe_d = {vld_pipe_q[STAGES-1:0], ivld};
        rdi_d      = ivld ? rdi : rdi_q;

        s2_d = s2_q;
        if (vld_pipe_q[0]) begin
            s2_d.allv  = &lane_v;
            s2_d.idok  = ~|id_bad;
            s2_d.refid = refid_c;
            s2_d.andm  = andm_c;
        end

        s3_d = s3_q;
        if (vld_pipe_q[1]) begin
            s3_d.hit    = hit_c;
            s3_d.ruleid = hit_c ? {s2_q.refid, idx_c} : '0;
            s3_d.multi  = hit_c && ((s2_q.andm & (s2_q.andm - MASKWID'(1))) != '0);
            s3_d.errev  = s2_q.allv && !s2_q.idok;
        end
    end

    // Output register: the priority encode is kept one stage ahead of the counter update.
    always_comb begin
        ovld_d   = vld_pipe_q[STAGES];
        hit_d    = vld_pipe_q[STAGES] && s3_q.hit;
        multi_d  = vld_pipe_q[STAGES] && s3_q.multi;
        ruleid_d = vld_pipe_q[STAGES] ? s3_q.ruleid : '0;

        lkcnt_d  = lkcnt_q;
        hitcnt_d = hitcnt_q;
        err_d    = err_q;
        if (clr) begin
            lkcnt_d  = '0;
            hitcnt_d = '0;
            err_d    = 1'b0;
        end else if (vld_pipe_q[STAGES]) begin
            if (lkcnt_q != '1) lkcnt_d = lkcnt_q + CNTWID'(1);
            if (s3_q.hit && hitcnt_q != '1) hitcnt_d = hitcnt_q + CNTWID'(1);
            if (s3_q.errev) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe_q <= '0;
            rdi_q      <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            ovld_q     <= 1'b0;
            hit_q      <= 1'b0;
            ruleid_q   <= '0;
            multi_q    <= 1'b0;
            err_q      <= 1'b0;
            lkcnt_q    <= '0;
            hitcnt_q   <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            rdi_q      <= rdi_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            ovld_q     <= ovld_d;
            hit_q      <= hit_d;
            ruleid_q   <= ruleid_d;
            multi_q    <= multi_d;
            err_q      <= err_d;
            lkcnt_q    <= lkcnt_d;
            hitcnt_q   <= hitcnt_d;
        end
    end

    assign ovld   = ovld_q;
    assign hit    = hit_q;
    assign ruleid = ruleid_q;
    assign multi  = multi_q;
    assign err    = err_q;
    assign lkcnt  = lkcnt_q;
    assign hitcnt = hitcnt_q;
endmodule

// File: tb/tb_segvect_match.sv
// Directed bench for segvect_match: a table of single lookups, plus clr, streaming, reset and saturation sequences.

module tb_segvect_match;
    logic         clk = 1'b0;
    logic         rst;
    logic [298:0] rdi;
    logic         ivld, clr, clr_s;
    logic         ovld, hit, multi, err;
    logic [11:0]  ruleid;
    logic [31:0]  lkcnt, hitcnt;
    logic         ovld_s, hit_s, multi_s, err_s;
    logic [11:0]  ruleid_s;
    logic [2:0]   lkcnt_s, hitcnt_s;

    always #5 clk = ~clk;

    segvect_match dut (
        .clk(clk), .rst(rst), .rdi(rdi), .ivld(ivld), .clr(clr),
        .ovld(ovld), .hit(hit), .ruleid(ruleid), .multi(multi), .err(err),
        .lkcnt(lkcnt), .hitcnt(hitcnt)
    );

    segvect_match #(.CNTWID(3)) dut_sat (
        .clk(clk), .rst(rst), .rdi(rdi), .ivld(ivld), .clr(clr_s),
        .ovld(ovld_s), .hit(hit_s), .ruleid(ruleid_s), .multi(multi_s), .err(err_s),
        .lkcnt(lkcnt_s), .hitcnt(hitcnt_s)
    );

    typedef struct {
        logic [298:0] rdi;
        logic         hit;
        logic [11:0]  ruleid;
        logic         multi;
        logic         err_set;
    } vec_t;

    vec_t tv[9];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_chk = 0;
    int   m_lk = 0, m_hc = 0;
    logic m_err = 1'b0;

    function automatic logic [22:0] mkw(input logic v, input logic wc, input logic [7:0] id, input logic [12:0] m);
        return {v, wc, id, m};
    endfunction

    function automatic logic [298:0] uni(input logic [22:0] w);
        logic [298:0] r;
        for (int k = 0; k < 13; k++) r[23*k +: 23] = w;
        return r;
    endfunction

    function automatic logic [298:0] setw(input logic [298:0] r, input int k, input logic [22:0] w);
        logic [298:0] o;
        o = r;
        o[23*k +: 23] = w;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Lookup presented at a negedge appears on the outputs at the fourth negedge after it.
    task automatic apply_one(input vec_t t, input string nm);
        rdi  = t.rdi;
        ivld = 1'b1;
        n_vec++;
        step();
        ivld = 1'b0;
        rdi  = '1;
        step();
        step();
        chk({nm, " early ovld"}, 32'(ovld), 32'd0);
        step();
        m_lk++;
        if (t.hit) m_hc++;
        if (t.err_set) m_err = 1'b1;
        chk({nm, " ovld"}, 32'(ovld), 32'd1);
        chk({nm, " hit"}, 32'(hit), 32'(t.hit));
        chk({nm, " ruleid"}, 32'(ruleid), 32'(t.ruleid));
        chk({nm, " multi"}, 32'(multi), 32'(t.multi));
        chk({nm, " err"}, 32'(err), 32'(m_err));
        chk({nm, " lkcnt"}, lkcnt, 32'(m_lk));
        chk({nm, " hitcnt"}, hitcnt, 32'(m_hc));
        step();
        chk({nm, " ovld drop"}, 32'(ovld), 32'd0);
        chk({nm, " hit held 0"}, 32'(hit), 32'd0);
    endtask

    initial begin
        logic [298:0] r;
        // single hit
        tv[0] = '{uni(mkw(1, 0, 8'h2A, 13'h0010)), 1'b1, 12'h2A4, 1'b0, 1'b0};
        // words 0..3 wildcarded with junk, survivors 0x0C00 -> bit 10, two bits left
        r = uni(mkw(1, 0, 8'h05, 13'h0C00));
        for (int k = 0; k < 4; k++) r = setw(r, k, mkw(1, 1, 8'hE0, 13'h1555));
        tv[1] = '{r, 1'b1, 12'h05A, 1'b1, 1'b0};
        // one invalid word
        tv[2] = '{setw(tv[0].rdi, 5, mkw(0, 0, 8'h2A, 13'h0010)), 1'b0, 12'h000, 1'b0, 1'b0};
        // disjoint masks
        r = '0;
        for (int k = 0; k < 13; k++) r = setw(r, k, mkw(1, 0, 8'h05, (k % 2 == 0) ? 13'h0001 : 13'h0002));
        tv[3] = '{r, 1'b0, 12'h000, 1'b0, 1'b0};
        // all wildcarded: segment 0 ID, all rules survive
        r = '0;
        for (int k = 0; k < 13; k++) r = setw(r, k, mkw(1, 1, 8'(8'h33 + k), 13'h0ABC));
        tv[4] = '{r, 1'b1, 12'h330, 1'b1, 1'b0};
        // only top rule bit
        tv[5] = '{uni(mkw(1, 0, 8'h7F, 13'h1000)), 1'b1, 12'h7FC, 1'b0, 1'b0};
        // disagreeing ID on an invalid word must not raise err
        tv[6] = '{setw(tv[0].rdi, 2, mkw(0, 0, 8'h99, 13'h0010)), 1'b0, 12'h000, 1'b0, 1'b0};
        // all valid, word 7 disagrees
        tv[7] = '{setw(uni(mkw(1, 0, 8'h05, 13'h0010)), 7, mkw(1, 0, 8'h06, 13'h0010)), 1'b0, 12'h000, 1'b0, 1'b1};
        // hit after the error: err stays set
        tv[8] = tv[0];

        rst = 1'b0; ivld = 1'b0; clr = 1'b0; clr_s = 1'b0; rdi = '0;
        #1;
        chk("reset ovld", 32'(ovld), 32'd0);
        chk("reset ruleid", 32'(ruleid), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset lkcnt", lkcnt, 32'd0);
        chk("reset hitcnt", hitcnt, 32'd0);
        @(negedge clk);
        step();
        rst = 1'b1;
        step();

        for (int i = 0; i < 9; i++) apply_one(tv[i], $sformatf("vec%0d", i));

        // clr on the edge that reports an err-setting lookup, then a hit right behind it
        rdi = tv[7].rdi; ivld = 1'b1; n_vec++; step();
        rdi = tv[0].rdi; n_vec++; step();
        ivld = 1'b0; step();
        clr = 1'b1; step();
        clr = 1'b0;
        chk("clr-err ovld", 32'(ovld), 32'd1);
        chk("clr-err lkcnt", lkcnt, 32'd0);
        chk("clr-err hitcnt", hitcnt, 32'd0);
        chk("clr-err err", 32'(err), 32'd0);
        step();
        chk("post-clr hit", 32'(hit), 32'd1);
        chk("post-clr lkcnt", lkcnt, 32'd1);
        chk("post-clr hitcnt", hitcnt, 32'd1);
        chk("post-clr err", 32'(err), 32'd0);

        // clr colliding with a hitting ovld
        rdi = tv[0].rdi; ivld = 1'b1; n_vec++; step();
        ivld = 1'b0; step(); step();
        clr = 1'b1; step();
        clr = 1'b0;
        chk("clr-hit ovld", 32'(ovld), 32'd1);
        chk("clr-hit hit", 32'(hit), 32'd1);
        chk("clr-hit lkcnt", lkcnt, 32'd0);
        chk("clr-hit hitcnt", hitcnt, 32'd0);
        step();

        // 20 back-to-back lookups alternating hit/miss
        for (int c = 0; c < 25; c++) begin
            if (c >= 4 && c < 24) begin
                chk($sformatf("stream%0d ovld", c - 4), 32'(ovld), 32'd1);
                chk($sformatf("stream%0d hit", c - 4), 32'(hit), (c % 2 == 0) ? 32'd1 : 32'd0);
                chk($sformatf("stream%0d ruleid", c - 4), 32'(ruleid), (c % 2 == 0) ? 32'h2A4 : 32'h0);
            end else begin
                chk($sformatf("stream idle%0d ovld", c), 32'(ovld), 32'd0);
            end
            if (c < 20) begin
                rdi  = (c % 2 == 0) ? tv[0].rdi : tv[3].rdi;
                ivld = 1'b1;
                n_vec++;
            end else begin
                ivld = 1'b0;
            end
            step();
        end
        chk("stream lkcnt", lkcnt, 32'd20);
        chk("stream hitcnt", hitcnt, 32'd10);

        // reset while two lookups are in flight
        rdi = tv[0].rdi; ivld = 1'b1; n_vec++; step();
        n_vec++; step();
        ivld = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst ovld", 32'(ovld), 32'd0);
        chk("midrst hit", 32'(hit), 32'd0);
        chk("midrst ruleid", 32'(ruleid), 32'd0);
        chk("midrst multi", 32'(multi), 32'd0);
        chk("midrst lkcnt", lkcnt, 32'd0);
        chk("midrst hitcnt", hitcnt, 32'd0);
        step();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("postrst%0d ovld", c), 32'(ovld), 32'd0);
            step();
        end
        m_lk = 0; m_hc = 0; m_err = 1'b0;
        apply_one(tv[0], "after-reset");

        // 3-bit counters must stick at all-ones
        clr_s = 1'b1; step(); clr_s = 1'b0;
        chk("sat cleared", 32'(lkcnt_s), 32'd0);
        for (int c = 0; c < 9; c++) begin
            rdi = tv[0].rdi; ivld = 1'b1; n_vec++; step();
        end
        ivld = 1'b0;
        for (int c = 0; c < 6; c++) step();
        chk("sat lkcnt", 32'(lkcnt_s), 32'd7);
        chk("sat hitcnt", 32'(hitcnt_s), 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
